fpgaaudio_multi_timer: RTL
==========================

# fpgaaudio_multi_timer

Parametrised multi-channel interval timer on an Avalon-MM slave, the successor to the single-channel system timer in the FPGAAudio SoC. It provides NUM_CH independent down-counters of CNT_W bits. A shared programmable prescaler drives all channels. Channels can be started simultaneously through a start mask, and optional cascading chains adjacent channels. The block has one level interrupt output to the Nios II IRQ controller, which is the OR of the enabled per-channel timeouts.

## Interface
- NUM_CH, 4, number of channels, 1..7
- CNT_W, 32, counter and period width, 8..32
- PRE_W, 16, prescaler width, 1..32
- DEFAULT_PERIOD, 49999, reset value of every period register and counter
- ADDR_W, 5, word address width; must satisfy 4*(NUM_CH+1) <= 2**ADDR_W
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  ADDR_W  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0
- writedata  in  32  write data
- readdata  out  32  registered read data; reset value 0
- irq  out  1  level interrupt; reset value 0

## Operation
- Global registers:
  - 0 GSTATUS: reads timeout[NUM_CH-1:0]. Writing 1 to a bit clears that bit.
  - 1 PRESCALE: PRE_W bits.
  - 2 GSTART: write-only. Each set bit n starts channel n. Reads 0.
  - 3 ID: reads 32'h4D54_0000 | NUM_CH<<8 | CNT_W.
- Channel n registers, at base 4*(n+1):
  - +0 STATUS: reads {running, timeout}. Any write clears timeout.
  - +1 CTRL: [0] ITO, [1] CONT, [2] START, [3] STOP, [4] CASC. Bits [1:0] and [4] are stored. START and STOP are write-only pulses and read 0.
  - +2 PERIOD: CNT_W bits, zero-extended on read.
  - +3 SNAP: any write copies the counter into SNAP. Reads return SNAP.
- Unmapped addresses read 0. Writes to unmapped addresses are ignored.
- Prescaler:
  - pre_cnt counts down to 0. When pre_cnt is 0, tick=1 for one cycle and pre_cnt reloads PRESCALE.
  - PRESCALE=0 gives tick every cycle.
  - A PRESCALE write reloads pre_cnt on the next cycle.
- Channel advance is the channel's step (tick, or the cascade pulse) while running.
  - counter != 0: counter decrements by 1.
  - counter == 0: counter reloads PERIOD, timeout sets, and running clears if CONT=0. The timeout interval is PERIOD+1 steps.
- A PERIOD write stops the channel. On the next cycle the counter loads the new PERIOD.
- Start and stop priority:
  - START and STOP written together: START wins.
  - START on a running channel does not reload the counter.
- irq = OR over all channels of (timeout & ITO).
- Simultaneous events:
  - A timeout set and a clear in the same cycle: the set wins, so no event is lost.
  - GSTART for a channel already running is a no-op.

## Timing
- Registers update on the clk edge where the write is asserted.
- The START write edge sets running. The first decrement occurs on the first step after that edge.
- readdata is captured every cycle from address, independent of chipselect. Read data is valid on the cycle after address is presented.
- timeout is set on the edge of the zero step. irq rises on that same edge.
- Reset:
  - counters = DEFAULT_PERIOD, PERIOD = DEFAULT_PERIOD.
  - PRESCALE = 0, pre_cnt = 0.
  - CTRL, SNAP, timeout and running = 0.
  - Reset asserted mid-count returns all state to these values immediately.

## Configuration
- MULTI_TIMER_CASCADE_EN defined:
  - For channel n>0 with CASC=1, the step is the zero-step pulse of channel n-1 instead of tick.
  - CASC on channel 0 is ignored.
  - This chains channels into CNT_W*k-bit timers.
- MULTI_TIMER_CASCADE_EN not defined:
  - CASC is not stored and reads 0.
  - All channels step on tick.

## Test plan
- Reset, read ID and PERIOD of ch0 -> ID = 32'h4D54_0420, PERIOD = 49999, readdata 0 before the first read, irq = 0.
- ch0: PERIOD=3, PRESCALE=0, CTRL=ITO|CONT|START -> timeout and irq every 4 clk. Write GSTATUS bit0 -> irq drops. Timeout and irq set again 4 clk after the previous set.
- ch1: PERIOD=2, PRESCALE=4, CTRL=START (one-shot) -> timeout 15 clk after start, running=0, counter holds at 2.
- Timeout coinciding with a STATUS clear write -> timeout reads 1 afterwards.
- GSTART=4'b0101 with ch0 and ch2 at PERIOD=5 -> both time out on the same cycle. SNAP write mid-count -> read value equals the counter at the write edge.
- Cascade (macro defined): ch0 PERIOD=1 CONT, ch1 PERIOD=2 CASC -> ch1 times out after 6 ticks. With the macro undefined, ch1 times out after 3 ticks and CTRL reads bit4 = 0.

Source files
------------

// File: rtl/fpgaaudio_multi_timer.sv
// fpgaaudio_multi_timer
//   Multi-channel interval timer on an Avalon-MM slave. NUM_CH independent
//   CNT_W-bit down-counters share one programmable prescaler. Channels can be
//   started together through GSTART. The level irq is the OR of the enabled
//   per-channel timeouts.
//
//   Optional feature: define MULTI_TIMER_CASCADE_EN to let channel n>0 step on
//   the zero-step pulse of channel n-1 (CTRL.CASC). Without the macro CASC is
//   not stored and every channel steps on the prescaler tick.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address (ADDR_W bits)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    registered read data, captured every cycle from address
//   irq         level interrupt
//
// Register map (word addresses)
//   0 GSTATUS  1 PRESCALE  2 GSTART  3 ID
//   4*(n+1) + {0 STATUS, 1 CTRL, 2 PERIOD, 3 SNAP} for channel n

module fpgaaudio_multi_timer #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int PRE_W          = 16,
  parameter int DEFAULT_PERIOD = 49999,
  parameter int ADDR_W         = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int BLK_W = ADDR_W - 2;
  localparam logic [31:0] ID_VAL = 32'h4D54_0000 | (32'(NUM_CH) << 8) | 32'(CNT_W);

  logic [BLK_W-1:0] blk;
  logic [1:0]       reg_sel;
  logic             wr;
  logic             unused_wdata;

  assign blk          = address[ADDR_W-1:2];
  assign reg_sel      = address[1:0];
  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pre_cnt;
  logic             pre_load;
  logic             tick;

  logic [CNT_W-1:0] counter [NUM_CH];
  logic [CNT_W-1:0] period  [NUM_CH];
  logic [CNT_W-1:0] snap    [NUM_CH];
  logic [NUM_CH-1:0] running, timeout, ito, cont, load_pend;
  logic [NUM_CH-1:0] step, zero_step;
`ifdef MULTI_TIMER_CASCADE_EN
  logic [NUM_CH-1:0] casc;
`endif

  logic gstatus_wr, prescale_wr, gstart_wr;
  logic [NUM_CH-1:0] wr_status, wr_ctrl, wr_period, wr_snap, start_req, stop_req, clr_req;

  always_comb begin
    gstatus_wr  = wr && (blk == '0) && (reg_sel == 2'd0);
    prescale_wr = wr && (blk == '0) && (reg_sel == 2'd1);
    gstart_wr   = wr && (blk == '0) && (reg_sel == 2'd2);
    for (int n = 0; n < NUM_CH; n++) begin
      wr_status[n] = wr && (blk == BLK_W'(n + 1)) && (reg_sel == 2'd0);
      wr_ctrl[n]   = wr && (blk == BLK_W'(n + 1)) && (reg_sel == 2'd1);
      wr_period[n] = wr && (blk == BLK_W'(n + 1)) && (reg_sel == 2'd2);
      wr_snap[n]   = wr && (blk == BLK_W'(n + 1)) && (reg_sel == 2'd3);
      start_req[n] = (wr_ctrl[n] & writedata[2]) | (gstart_wr & writedata[n]);
      stop_req[n]  = wr_ctrl[n] & writedata[3];
      clr_req[n]   = wr_status[n] | (gstatus_wr & writedata[n]);
    end
  end

  // A freshly written PRESCALE is loaded one cycle later; the tick is held off
  // during that cycle so the new interval starts cleanly.
  assign tick = (pre_cnt == '0) & ~pre_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale <= '0;
      pre_cnt  <= '0;
      pre_load <= 1'b0;
    end else begin
      pre_load <= prescale_wr;
      if (prescale_wr) prescale <= writedata[PRE_W-1:0];
      if (pre_load || pre_cnt == '0) pre_cnt <= prescale;
      else                           pre_cnt <= pre_cnt - PRE_W'(1);
    end
  end

  // Step selection ripples through the chain in channel order so a cascade of
  // several channels resolves within one cycle.
  always_comb begin
    step      = '0;
    zero_step = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      step[n] = tick;
`ifdef MULTI_TIMER_CASCADE_EN
      if (n > 0 && casc[n]) step[n] = zero_step[(n > 0) ? n - 1 : 0];
`endif
      zero_step[n] = step[n] & running[n] & (counter[n] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_CH; n++) begin
        counter[n] <= CNT_W'(DEFAULT_PERIOD);
        period[n]  <= CNT_W'(DEFAULT_PERIOD);
        snap[n]    <= '0;
      end
      running   <= '0;
      timeout   <= '0;
      ito       <= '0;
      cont      <= '0;
      load_pend <= '0;
`ifdef MULTI_TIMER_CASCADE_EN
      casc      <= '0;
`endif
    end else begin
      load_pend <= wr_period;
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_snap[n]) snap[n] <= counter[n];

        if (load_pend[n])
          counter[n] <= period[n];
        else if (step[n] && running[n])
          counter[n] <= (counter[n] == '0) ? period[n] : counter[n] - CNT_W'(1);

        if (wr_period[n]) period[n] <= writedata[CNT_W-1:0];

        // START beats STOP, PERIOD-write stop and one-shot completion.
        if (start_req[n])
          running[n] <= 1'b1;
        else if (stop_req[n] || wr_period[n] || (zero_step[n] && !cont[n]))
          running[n] <= 1'b0;

        // A set in the same cycle as a clear wins so no timeout is lost.
        if (zero_step[n])    timeout[n] <= 1'b1;
        else if (clr_req[n]) timeout[n] <= 1'b0;

        if (wr_ctrl[n]) begin
          ito[n]  <= writedata[0];
          cont[n] <= writedata[1];
`ifdef MULTI_TIMER_CASCADE_EN
          casc[n] <= writedata[4];
`endif
        end
      end
    end
  end

  logic [31:0] rd_next;

  always_comb begin
    rd_next = '0;
    if (blk == '0) begin
      case (reg_sel)
        2'd0:    rd_next[NUM_CH-1:0] = timeout;
        2'd1:    rd_next[PRE_W-1:0]  = prescale;
        2'd3:    rd_next             = ID_VAL;
        default: rd_next             = '0;
      endcase
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (blk == BLK_W'(n + 1)) begin
        case (reg_sel)
          2'd0: rd_next[1:0] = {running[n], timeout[n]};
          2'd1: begin
            rd_next[1:0] = {cont[n], ito[n]};
`ifdef MULTI_TIMER_CASCADE_EN
            rd_next[4]   = casc[n];
`endif
          end
          2'd2:    rd_next[CNT_W-1:0] = period[n];
          default: rd_next[CNT_W-1:0] = snap[n];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(timeout & ito);

endmodule
